// File: rtl/oled_text_streamer.sv
// oled_text_streamer
// Snapshots the eight ASCII digit characters of the soda machine status,
// merges them into a fixed 4x16 text frame and streams the frame to the
// OLED character controller one character per valid/ready transfer.

module oled_text_streamer #(
    parameter bit STATIC_ONCE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    input  logic [7:0] coins_hund,
    input  logic [7:0] coins_units,
    input  logic [7:0] cost_dol,
    input  logic [7:0] cost_hund,
    input  logic [7:0] cost_units,
    input  logic [7:0] tot_dol,
    input  logic [7:0] tot_hund,
    input  logic [7:0] tot_units,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [1:0] char_row,
    output logic [3:0] char_col,
    output logic [7:0] char_data,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t     state_q;
    logic       pending_q;
    logic       first_q;
    logic [5:0] index_q;
    logic       valid_q;
    logic       busy_q;
    logic       frameDone_q;

    logic [7:0] coinsHund_q;
    logic [7:0] coinsUnits_q;
    logic [7:0] costDol_q;
    logic [7:0] costHund_q;
    logic [7:0] costUnits_q;
    logic [7:0] totDol_q;
    logic [7:0] totHund_q;
    logic [7:0] totUnits_q;

    logic [1:0] row;
    logic [3:0] col;
    logic [7:0] charData_d;

    assign row = index_q[5:4];
    assign col = index_q[3:0];

    // Frame sequencer: request latching, snapshot capture, index stepping and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b1;
            first_q      <= 1'b1;
            index_q      <= 6'd0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frameDone_q  <= 1'b0;
            coinsHund_q  <= 8'h20;
            coinsUnits_q <= 8'h20;
            costDol_q    <= 8'h20;
            costHund_q   <= 8'h20;
            costUnits_q  <= 8'h20;
            totDol_q     <= 8'h20;
            totHund_q    <= 8'h20;
            totUnits_q   <= 8'h20;
        end else begin
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                LOAD: begin
                    coinsHund_q  <= coins_hund;
                    coinsUnits_q <= coins_units;
                    costDol_q    <= cost_dol;
                    costHund_q   <= cost_hund;
                    costUnits_q  <= cost_units;
                    totDol_q     <= tot_dol;
                    totHund_q    <= tot_hund;
                    totUnits_q   <= tot_units;
                    index_q      <= (first_q || !STATIC_ONCE) ? 6'd0 : 6'd16;
                    valid_q      <= 1'b1;
                    state_q      <= SEND;
                end
                SEND: begin
                    if (char_ready) begin
                        index_q <= index_q + 6'd1;
                        if (index_q == 6'd63) begin
                            valid_q     <= 1'b0;
                            frameDone_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    first_q <= 1'b0;
                    if (pending_q) begin
                        state_q   <= LOAD;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
            // A fresh request always survives, even when it lands on the cycle that consumes the previous one.
            if (update) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Character decode from the registered index and snapshot; index 0 decodes to a blank so reset shows 0x20.
    always_comb begin
        charData_d = 8'h20;
        case (row)
            2'd0: begin
                case (col)
                    4'd2:    charData_d = "S";
                    4'd3:    charData_d = "O";
                    4'd4:    charData_d = "D";
                    4'd5:    charData_d = "A";
                    4'd7:    charData_d = "M";
                    4'd8:    charData_d = "A";
                    4'd9:    charData_d = "C";
                    4'd10:   charData_d = "H";
                    4'd11:   charData_d = "I";
                    4'd12:   charData_d = "N";
                    4'd13:   charData_d = "E";
                    default: charData_d = 8'h20;
                endcase
            end
            2'd1: begin
                case (col)
                    4'd0:    charData_d = "C";
                    4'd1:    charData_d = "O";
                    4'd2:    charData_d = "I";
                    4'd3:    charData_d = "N";
                    4'd4:    charData_d = "S";
                    4'd5:    charData_d = ":";
                    4'd14:   charData_d = coinsHund_q;
                    4'd15:   charData_d = coinsUnits_q;
                    default: charData_d = 8'h20;
                endcase
            end
            2'd2: begin
                case (col)
                    4'd0:    charData_d = "C";
                    4'd1:    charData_d = "O";
                    4'd2:    charData_d = "S";
                    4'd3:    charData_d = "T";
                    4'd4:    charData_d = ":";
                    4'd11:   charData_d = "$";
                    4'd12:   charData_d = costDol_q;
                    4'd13:   charData_d = ".";
                    4'd14:   charData_d = costHund_q;
                    4'd15:   charData_d = costUnits_q;
                    default: charData_d = 8'h20;
                endcase
            end
            default: begin
                case (col)
                    4'd0:    charData_d = "P";
                    4'd1:    charData_d = "A";
                    4'd2:    charData_d = "I";
                    4'd3:    charData_d = "D";
                    4'd4:    charData_d = ":";
                    4'd11:   charData_d = "$";
                    4'd12:   charData_d = totDol_q;
                    4'd13:   charData_d = ".";
                    4'd14:   charData_d = totHund_q;
                    4'd15:   charData_d = totUnits_q;
                    default: charData_d = 8'h20;
                endcase
            end
        endcase
    end

    assign char_valid = valid_q;
    assign char_row   = row;
    assign char_col   = col;
    assign char_data  = charData_d;
    assign busy       = busy_q;
    assign frame_done = frameDone_q;

endmodule

// File: doc/oled_text_streamer.md
# oled_text_streamer

Downstream consumer of the soda machine's ASCII digit converter. On each update request it snapshots the eight ASCII digit characters (coin count, cost, total paid) and merges them into a fixed 4-row × 16-column text frame. It then streams the frame one character at a time to the OLED character controller over a valid/ready handshake, with row/column addressing.

## Interface
- `STATIC_ONCE`, default 1: when 1, row 0 (the static banner) is sent only in the first frame after reset. Every later frame sends rows 1–3 only (48 characters). When 0, every frame sends all 64 characters.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `update` input 1: single-cycle refresh request.
- `coins_hund`, `coins_units` input 8 each: ASCII tens and units digits of the coin count.
- `cost_dol`, `cost_hund`, `cost_units` input 8 each: ASCII dollars, dimes and cents digits of the cost.
- `tot_dol`, `tot_hund`, `tot_units` input 8 each: ASCII dollars, dimes and cents digits of the total paid.
- `char_ready` input 1: the controller accepts a character.
- `char_valid` output 1: a character is presented.
- `char_row` output 2: destination row, 0–3.
- `char_col` output 4: destination column, 0–15.
- `char_data` output 8: ASCII character.
- `busy` output 1: high whenever the state is not IDLE.
- `frame_done` output 1: one-cycle pulse after the last transfer of a frame.

## Operation
- Frame layout (all blank positions are 0x20):
  - Row 0: `"  SODA MACHINE  "`.
  - Row 1: cols 0–5 `"COINS:"`, cols 6–13 blank, col 14 `coins_hund`, col 15 `coins_units`.
  - Row 2: cols 0–4 `"COST:"`, cols 5–10 blank, col 11 `'$'`, col 12 `cost_dol`, col 13 `'.'`, col 14 `cost_hund`, col 15 `cost_units`.
  - Row 3: same as row 2 but with `"PAID:"` and the `tot_*` digits.
- Digit inputs pass through unaltered; no validation is done. A 0x20 input appears as a blank.
- `pending` register:
  - Set by `update` in any state.
  - Reset value is 1, so a full frame is sent automatically after reset.
  - Cleared on the IDLE→LOAD transition. If `update` arrives in that same cycle, the set wins.
- `first` register:
  - Reset value is 1.
  - Cleared on leaving DONE.
- States:
  - IDLE: go to LOAD when `pending` is 1.
  - LOAD: capture all eight digit inputs into snapshot registers. Load the 6-bit index with 0 if `first` is 1 or `STATIC_ONCE` is 0, otherwise with 16. Go to SEND.
  - SEND: `char_valid` is 1. `char_row` = index[5:4], `char_col` = index[3:0], `char_data` comes from the layout using snapshot values only.
    - On `char_valid && char_ready`, the index increments.
    - When index 63 is transferred, go to DONE.
  - DONE: `frame_done` is 1 for this single cycle. Then go to LOAD if `pending` is 1, else IDLE.
- Handshake rules:
  - While `char_valid` is 1 and `char_ready` is 0, `char_row`, `char_col` and `char_data` hold stable.
  - `char_valid` never drops without a transfer, except on reset.
- Characters are sent in row-major order with no skips and no duplicates.
- Changes on the digit inputs after LOAD have no effect on the frame in flight.

## Timing
- Reset values of outputs: `char_valid` 0, `char_row` 0, `char_col` 0, `char_data` 0x20, `busy` 0, `frame_done` 0.
- Reset values of internal state: state IDLE, `pending` 1, `first` 1, index 0.
- Outputs are registered; the `char_*` outputs may be decoded from the registered index and snapshot.
- Request latency from IDLE:
  - `update` sampled at edge k.
  - IDLE→LOAD at edge k+1.
  - LOAD→SEND at edge k+2; the snapshot is captured at this edge.
  - `char_valid` is first high in the cycle after edge k+2.
- Throughput with `char_ready` held at 1: one character per cycle.
  - A full frame takes 64 cycles in SEND and 1 cycle in DONE.
  - A partial frame takes 48 cycles in SEND and 1 cycle in DONE.
- Back-to-back frames: DONE goes to LOAD directly, so there is a 2-cycle gap between the last transfer and the next `char_valid`.
- Multiple `update` pulses during LOAD, SEND or DONE coalesce into exactly one follow-up frame.
- Asserting `rst_n` low mid-frame forces all outputs to their reset values immediately (asynchronously). The frame is abandoned. After release, a full 64-character frame is sent, including row 0.

## Test plan
- Reset release, `char_ready`=1, digits all 0x30: exactly 64 transfers in order.
  - Row 0 col 2 = 0x53; row 2 col 11 = 0x24; row 3 col 13 = 0x2E.
  - `frame_done` pulses once, then `busy` goes 0.
- After the first frame, `update` with coins 0x30/0x33, cost 0x31/0x32/0x35, tot 0x30/0x37/0x35:
  - 48 transfers, starting at row 1 col 0 = 0x43.
  - Row 1 col 15 = 0x33; row 2 col 12 = 0x31; row 3 col 15 = 0x35.
  - First `char_valid` appears 3 cycles after `update`.
- Hold `char_ready` low for 5 cycles at row 2 col 12: `char_valid`, row, col and data stay constant; the next accepted character is row 2 col 13.
- Change every digit input and pulse `update` three times during SEND:
  - The current frame still carries the old snapshot.
  - Exactly one extra frame follows, carrying the new values.
  - No third frame is sent.
- Pulse `update` in the same cycle as IDLE→LOAD: `pending` stays 1 and a second frame follows immediately after DONE.
- Assert `rst_n` low after 20 transfers: `char_valid` goes 0 without waiting for a clock edge. After release, a full 64-character frame is sent starting at row 0 col 0.
